// File: rtl/mux2_rr.sv
// Two-channel round-robin merge stage with one holding register per input and a registered output.
// Each output word carries a source tag so a downstream demux can route it back by channel.
module mux2_rr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] y,
    output logic             s,
    output logic             y_valid,
    input  logic             y_ready
);

    logic [WIDTH-1:0] r_h0_data;
    logic [WIDTH-1:0] r_h1_data;
    logic             r_h0_full;
    logic             r_h1_full;
    logic [WIDTH-1:0] r_y;
    logic             r_s;
    logic             r_y_valid;
    logic             r_last;

    logic             w_load;
    logic             w_grant;
    logic             w_cap0;
    logic             w_cap1;

    always_comb begin
        w_load  = (~r_y_valid | y_ready) & (r_h0_full | r_h1_full);
        // Contention goes to the channel not granted last; otherwise the only full one wins.
        w_grant = (r_h0_full & r_h1_full) ? ~r_last : r_h1_full;
        w_cap0  = i0_valid & ~r_h0_full;
        w_cap1  = i1_valid & ~r_h1_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h0_data <= '0;
            r_h1_data <= '0;
            r_h0_full <= 1'b0;
            r_h1_full <= 1'b0;
            r_y       <= '0;
            r_s       <= 1'b0;
            r_y_valid <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            // Capture and drain of one holding register are mutually exclusive (full vs empty).
            if (w_cap0) begin
                r_h0_data <= i0_data;
                r_h0_full <= 1'b1;
            end else if (w_load && !w_grant) begin
                r_h0_full <= 1'b0;
            end

            if (w_cap1) begin
                r_h1_data <= i1_data;
                r_h1_full <= 1'b1;
            end else if (w_load && w_grant) begin
                r_h1_full <= 1'b0;
            end

            if (w_load) begin
                r_y       <= w_grant ? r_h1_data : r_h0_data;
                r_s       <= w_grant;
                r_y_valid <= 1'b1;
                r_last    <= w_grant;
            end else if (y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign i0_ready = rst_n & ~r_h0_full;
    assign i1_ready = rst_n & ~r_h1_full;
    assign y        = r_y;
    assign s        = r_s;
    assign y_valid  = r_y_valid;

endmodule

// File: tb/tb_mux2_rr.sv
// Scoreboard bench for mux2_rr: per-channel expected queues are filled on input handshakes
// and drained on output handshakes, routed by the source tag as a demux would.
module tb_mux2_rr;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NWORDS = 200;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] i0_data;
    logic             i0_valid;
    logic             i0_ready;
    logic [WIDTH-1:0] i1_data;
    logic             i1_valid;
    logic             i1_ready;
    logic [WIDTH-1:0] y;
    logic             s;
    logic             y_valid;
    logic             y_ready;

    mux2_rr #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0_data  (i0_data),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1_data  (i1_data),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .y        (y),
        .s        (s),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Values applied at the next falling edge.
    logic             nx_rst = 1'b0;
    logic             nx_v0 = 1'b0;
    logic             nx_v1 = 1'b0;
    logic [WIDTH-1:0] nx_d0 = '0;
    logic [WIDTH-1:0] nx_d1 = '0;
    logic             nx_yr = 1'b0;
    bit               stream_en = 1'b0;
    bit               rand_en = 1'b0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int unsigned      acc0 = 0;
    int unsigned      acc1 = 0;
    int unsigned      outs = 0;
    bit               alt_en = 1'b0;
    logic             exp_tag = 1'b0;

    bit               prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_y = '0;
    logic             prev_s = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, then sample handshakes that the next rising edge commits.
    task automatic step();
        logic [WIDTH-1:0] exp_w;
        @(negedge clk);
        if (rand_en) begin
            nx_v0 = (acc0 < NWORDS) && ($urandom_range(0, 1) == 1);
            nx_v1 = (acc1 < NWORDS) && ($urandom_range(0, 1) == 1);
            nx_d0 = WIDTH'($urandom);
            nx_d1 = WIDTH'($urandom);
            nx_yr = ($urandom_range(0, 2) != 0);
        end
        if (stream_en) begin
            nx_d0 = WIDTH'(8'h10 + acc0);
            nx_d1 = WIDTH'(8'h20 + acc1);
        end
        rst_n    = nx_rst;
        i0_valid = nx_v0;
        i0_data  = nx_d0;
        i1_valid = nx_v1;
        i1_data  = nx_d1;
        y_ready  = nx_yr;
        #1;
        if (prev_hold) begin
            check("hold_y", 32'(y), 32'(prev_y));
            check("hold_s", 32'(s), 32'(prev_s));
            check("hold_valid", 32'(y_valid), 32'd1);
        end
        if (i0_valid && i0_ready) begin
            q0.push_back(i0_data);
            acc0++;
        end
        if (i1_valid && i1_ready) begin
            q1.push_back(i1_data);
            acc1++;
        end
        if (y_valid && y_ready && rst_n) begin
            outs++;
            if (s) begin
                if (q1.size() == 0) check("sb1_empty", 32'd0, 32'd1);
                else begin
                    exp_w = q1.pop_front();
                    check("sb1_data", 32'(y), 32'(exp_w));
                end
            end else begin
                if (q0.size() == 0) check("sb0_empty", 32'd0, 32'd1);
                else begin
                    exp_w = q0.pop_front();
                    check("sb0_data", 32'(y), 32'(exp_w));
                end
            end
            if (alt_en) begin
                check("rr_tag", 32'(s), 32'(exp_tag));
                exp_tag = ~exp_tag;
            end
        end
        prev_hold = rst_n && y_valid && !y_ready;
        prev_y    = y;
        prev_s    = s;
    endtask

    task automatic do_reset();
        nx_rst = 1'b0;
        nx_v0 = 1'b0;
        nx_v1 = 1'b0;
        stream_en = 1'b0;
        rand_en = 1'b0;
        alt_en = 1'b0;
        step();
        step();
        nx_rst = 1'b1;
        q0.delete();
        q1.delete();
        acc0 = 0;
        acc1 = 0;
        outs = 0;
    endtask

    // Fill all three buffer slots from both streaming channels with the output stalled.
    task automatic fill_stalled();
        stream_en = 1'b1;
        nx_v0 = 1'b1;
        nx_v1 = 1'b1;
        nx_yr = 1'b0;
        repeat (8) step();
        check("bp_accepted", 32'(acc0 + acc1), 32'd3);
        check("bp_i0_ready", 32'(i0_ready), 32'd0);
        check("bp_i1_ready", 32'(i1_ready), 32'd0);
        check("bp_y_valid", 32'(y_valid), 32'd1);
        check("bp_y", 32'(y), 32'h10);
        nx_v0 = 1'b0;
        nx_v1 = 1'b0;
        stream_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i0_valid = 1'b0;
        i1_valid = 1'b0;
        i0_data = '0;
        i1_data = '0;
        y_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_y", 32'(y), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_i0_ready_low", 32'(i0_ready), 32'd0);
        check("rst_i1_ready_low", 32'(i1_ready), 32'd0);

        // Single word on channel 0
        nx_v0 = 1'b1;
        nx_d0 = 8'hA5;
        nx_yr = 1'b1;
        step();
        check("rel_i0_ready", 32'(i0_ready), 32'd1);
        check("rel_i1_ready", 32'(i1_ready), 32'd1);
        check("single_acc", 32'(acc0), 32'd1);
        nx_v0 = 1'b0;
        step();
        check("single_i0_busy", 32'(i0_ready), 32'd0);
        check("single_not_yet", 32'(y_valid), 32'd0);
        step();
        check("single_y", 32'(y), 32'hA5);
        check("single_s", 32'(s), 32'd0);
        check("single_valid", 32'(y_valid), 32'd1);
        check("single_i0_free", 32'(i0_ready), 32'd1);
        step();
        check("single_valid_drop", 32'(y_valid), 32'd0);

        // Contention: strict alternation, one word per cycle once primed
        do_reset();
        stream_en = 1'b1;
        nx_v0 = 1'b1;
        nx_v1 = 1'b1;
        nx_yr = 1'b1;
        alt_en = 1'b1;
        exp_tag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 2) check("rr_full_rate", 32'(y_valid), 32'd1);
        end
        check("rr_out_count", 32'(outs), 32'd18);
        alt_en = 1'b0;
        nx_v0 = 1'b0;
        nx_v1 = 1'b0;
        stream_en = 1'b0;
        repeat (6) step();
        check("rr_drained", 32'(q0.size() + q1.size()), 32'd0);

        // Backpressure: three words buffered, then round-robin drain
        do_reset();
        fill_stalled();
        nx_yr = 1'b1;
        alt_en = 1'b1;
        exp_tag = 1'b0;
        outs = 0;
        repeat (6) step();
        alt_en = 1'b0;
        check("bp_drain_count", 32'(outs), 32'd3);
        check("bp_drained", 32'(q0.size() + q1.size()), 32'd0);

        // Reset with three words buffered
        do_reset();
        fill_stalled();
        nx_rst = 1'b0;
        step();
        check("mid_rst_i0_ready", 32'(i0_ready), 32'd0);
        check("mid_rst_i1_ready", 32'(i1_ready), 32'd0);
        nx_rst = 1'b1;
        step();
        check("mid_rst_y_valid", 32'(y_valid), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        q0.delete();
        q1.delete();
        acc0 = 0;
        acc1 = 0;
        stream_en = 1'b1;
        nx_v0 = 1'b1;
        nx_v1 = 1'b1;
        nx_yr = 1'b1;
        alt_en = 1'b1;
        exp_tag = 1'b0;
        outs = 0;
        repeat (8) step();
        check("mid_rst_outs", 32'(outs), 32'd6);
        alt_en = 1'b0;

        // Random valid/ready traffic, 200 words per channel
        do_reset();
        rand_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (acc0 >= NWORDS && acc1 >= NWORDS && q0.size() == 0 && q1.size() == 0) break;
        end
        rand_en = 1'b0;
        check("rand_acc0", 32'(acc0), 32'(NWORDS));
        check("rand_acc1", 32'(acc1), 32'(NWORDS));
        check("rand_outs", 32'(outs), 32'(2 * NWORDS));
        check("rand_left", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux2_rr.md
# mux2_rr

Two-channel round-robin merge stage: accepts words from two independent valid/ready producer channels and merges them onto a single output channel. Each word carries a 1-bit source tag `s`, so a downstream `demux` can steer it back to output 0 or 1 from the tag. Each input has a one-word holding register and the output is a registered stage, so no combinational path runs from `y_ready` to either `iN_ready`.

## Interface
- `WIDTH`, default 8: data word width in bits.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `i0_data`  input  WIDTH  channel 0 word.
- `i0_valid`  input  1  channel 0 word present.
- `i0_ready`  output  1  channel 0 holding register empty; transfer occurs on `i0_valid & i0_ready`.
- `i1_data`  input  WIDTH  channel 1 word.
- `i1_valid`  input  1  channel 1 word present.
- `i1_ready`  output  1  channel 1 holding register empty.
- `y`  output  WIDTH  merged output word (registered).
- `s`  output  1  source tag of `y`: 0 means from channel 0, 1 means from channel 1 (registered).
- `y_valid`  output  1  `y`/`s` hold a valid word (registered).
- `y_ready`  input  1  downstream accepts; transfer occurs on `y_valid & y_ready`.

## Operation
- State:
  - `h0`/`h1`: holding registers, each WIDTH bits plus a full flag.
  - Output register: `y`, `s`, `y_valid`.
  - `last`: 1-bit round-robin pointer holding the most recently granted channel.
- Readiness: `iN_ready = rst_n & ~hN_full`, a purely registered-state function.
  - A channel cannot accept in the same cycle its held word is drained.
  - Per-channel throughput is therefore at most 1 word per 2 cycles; combined throughput is 1 word per cycle when both channels are active.
- Input capture: on `iN_valid & iN_ready`, load `hN` with `iN_data` and set `hN_full`.
- Output load enable: `load = (~y_valid | y_ready) & (h0_full | h1_full)`.
- Grant on `load`:
  - Only one holding register full: grant that channel.
  - Both full: grant `~last`, which alternates strictly between channels.
  - On grant: `y <= hG`, `s <= G`, `y_valid <= 1`, clear `hG_full`, `last <= G`.
- Output drain:
  - On `y_valid & y_ready` with no `load`: `y_valid <= 0`.
  - `y` and `s` hold their last values while `y_valid` is 0.
- Output stability: while `y_valid & ~y_ready`, `y`, `s` and `y_valid` must not change. Arbitration is frozen and `last` does not move.
- Simultaneous events:
  - Drain and load in the same cycle: the new word replaces the old one; `y_valid` stays 1.
  - The non-granted channel keeps its word and may not accept new input while full.
- Width rules: data passes through unmodified; there is no arithmetic.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - `y` = 0, `s` = 0, `y_valid` = 0, `h0_full` = `h1_full` = 0, `last` = 1, so channel 0 wins the first contention.
  - `i0_ready` and `i1_ready` are 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset mid-operation: held and output words are discarded without being presented; there is no partial state.
- Latency: a word accepted at edge E appears on `y` with `y_valid` = 1 after edge E+1, provided the output stage is free and the word wins arbitration. Minimum input-to-output latency is 2 edges.
- Contention: with both channels continuously valid and `y_ready` = 1, the output sequence of `s` is 0,1,0,1,... starting after reset.
- Backpressure: with `y_ready` = 0, at most 3 words are buffered (1 in the output register and 1 per holding register). After that, both `iN_ready` are 0.

## Test plan
- Reset, then `i0_data`=8'hA5 with `i0_valid` pulsed for one cycle and `y_ready`=1 -> 2 edges after acceptance `y`=8'hA5, `s`=0, `y_valid`=1 for exactly 1 cycle; `i0_ready` is 0 for 1 cycle only.
- Both channels held valid (ch0 = 8'h10, 8'h11, ...; ch1 = 8'h20, 8'h21, ...), `y_ready`=1 -> output sequence 10(s0), 20(s1), 11(s0), 21(s1), ...; one word per cycle once primed.
- Hold `y_ready`=0 with both channels streaming -> exactly 3 words accepted, `y` stable, both readies 0. Release `y_ready` -> all 3 words drain in round-robin order, none lost or duplicated.
- Toggle `y_ready` randomly, 200 words per channel -> scoreboard per-channel order is preserved, tags are correct, and `y` never changes while `y_valid & ~y_ready`.
- Assert `rst_n`=0 for 1 cycle while 3 words are buffered -> next cycle `y_valid`=0, `y`=0, `s`=0, readies 0; after release the first contended grant goes to channel 0.
- Loopback: `mux2_rr` output drives `demux` using `s` as the select -> each word emerges on the `demux` output matching its source channel.
